serial_step_tx: RTL and testbench

//   Serial step-stream transmitter: accepts a parallel word on a valid/ready

---
 rtl/serial_step_tx.sv | 157 +++++++++++++++
 tb/tb_serial_step_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_step_tx.sv
// Serial step-stream transmitter with a cycle-accurate mirror of the downstream 4-state sequencer.
// Optional parity cycle after the data bits is enabled by defining PARITY_EN.
module serial_step_tx #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x_out,
  output logic             busy,
  output logic             frame_done,
  output logic [1:0]       mirror_state,
  output logic             mirror_y
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [7:0]      GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

`ifdef PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    GAP_S = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP_S = 2'd3
  } state_t;
`endif

  localparam state_t AFTER_FRAME = (GAP == 0) ? IDLE : GAP_S;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic [7:0]       gap_cnt;
`ifdef PARITY_EN
  logic             parity_reg;
`endif

  // The head bit goes out directly on acceptance; shift_reg keeps the remaining bits
  // aligned so the next bit to send is always at the same end.
  logic             first_bit;
  logic [WIDTH-1:0] rest_in;
  logic             head_bit;
  logic [WIDTH-1:0] rest_shift;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign first_bit  = data_in[WIDTH-1];
      assign rest_in    = {data_in[WIDTH-2:0], 1'b0};
      assign head_bit   = shift_reg[WIDTH-1];
      assign rest_shift = {shift_reg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign first_bit  = data_in[0];
      assign rest_in    = {1'b0, data_in[WIDTH-1:1]};
      assign head_bit   = shift_reg[0];
      assign rest_shift = {1'b0, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  assign data_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      x_out      <= 1'b0;
      frame_done <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= 8'd0;
`ifdef PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          x_out <= 1'b0;
          if (data_valid) begin
            x_out     <= first_bit;
            shift_reg <= rest_in;
            bit_cnt   <= '0;
`ifdef PARITY_EN
            parity_reg <= ^data_in;
`endif
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_EN
            x_out <= parity_reg;
            state <= PAR;
`else
            x_out      <= 1'b0;
            frame_done <= 1'b1;
            gap_cnt    <= 8'd0;
            state      <= AFTER_FRAME;
`endif
          end else begin
            x_out     <= head_bit;
            shift_reg <= rest_shift;
            bit_cnt   <= bit_cnt + CW'(1);
          end
        end
`ifdef PARITY_EN
        PAR: begin
          x_out      <= 1'b0;
          frame_done <= 1'b1;
          gap_cnt    <= 8'd0;
          state      <= AFTER_FRAME;
        end
`endif
        GAP_S: begin
          // The frame_done cycle is the first of the GAP idle cycles.
          x_out <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          x_out <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Sequencer mirror: steps 00->10->11->01->00 on each x_out=1 cycle, holds otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mirror_state <= 2'b00;
    end else if (x_out) begin
      case (mirror_state)
        2'b00:   mirror_state <= 2'b10;
        2'b10:   mirror_state <= 2'b11;
        2'b11:   mirror_state <= 2'b01;
        default: mirror_state <= 2'b00;
      endcase
    end
  end

  assign mirror_y = (mirror_state == 2'b11);

endmodule

// File: tb/tb_serial_step_tx.sv
// Directed bench for serial_step_tx: a GAP=2 LSB-first instance and a GAP=0 MSB-first instance.
module tb_serial_step_tx;

  localparam int TW = 8;
`ifdef PARITY_EN
  localparam int PLEN = 1;
`else
  localparam int PLEN = 0;
`endif

  logic          CLK;
  logic          RST;
  logic [TW-1:0] di, di0;
  logic          dv, dv0;
  logic          rdy, rdy0, xo, xo0, bsy, bsy0, fd, fd0, my, my0;
  logic [1:0]    ms, ms0;

  int checks = 0;
  int errors = 0;

  logic   q[$];
  logic   q0[$];
  logic   ex, ex0;
  logic [1:0] m, m0;

  serial_step_tx #(.WIDTH(TW), .GAP(2), .MSB_FIRST(1'b0)) dut (
    .CLK(CLK), .RST(RST), .data_in(di), .data_valid(dv), .data_ready(rdy),
    .x_out(xo), .busy(bsy), .frame_done(fd), .mirror_state(ms), .mirror_y(my)
  );

  serial_step_tx #(.WIDTH(TW), .GAP(0), .MSB_FIRST(1'b1)) dut0 (
    .CLK(CLK), .RST(RST), .data_in(di0), .data_valid(dv0), .data_ready(rdy0),
    .x_out(xo0), .busy(bsy0), .frame_done(fd0), .mirror_state(ms0), .mirror_y(my0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [1:0] adv(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance the mirror models with the x_out expected in the cycle being left.
  task automatic step();
    if (ex)  m  = adv(m);
    if (ex0) m0 = adv(m0);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    m = 2'b00; m0 = 2'b00; ex = 1'b0; ex0 = 1'b0;
  endtask

  task automatic chk_mirror();
    chk("mirror_state", 32'(ms), 32'(m));
    chk("mirror_y", 32'(my), 32'(m == 2'b11));
    chk("mirror_state0", 32'(ms0), 32'(m0));
  endtask

  // One frame on the GAP=2 instance, handshake in the current cycle.
  task automatic frame(input logic [TW-1:0] w);
    chk("ready_at_handshake", 32'(rdy), 32'd1);
    dv = 1'b1; di = w;
    for (int i = 0; i < TW; i++) q.push_back(w[i]);
    if (PLEN == 1) q.push_back(^w);
    ex = 1'b0;
    step();
    dv = 1'b0; di = TW'($urandom);
    while (q.size() > 0) begin
      ex = q.pop_front();
      chk("x_bit", 32'(xo), 32'(ex));
      chk("busy_shift", 32'(bsy), 32'd1);
      chk("ready_shift", 32'(rdy), 32'd0);
      chk("done_early", 32'(fd), 32'd0);
      chk_mirror();
      step();
    end
    ex = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("x_gap", 32'(xo), 32'd0);
      chk("ready_gap", 32'(rdy), 32'd0);
      chk("busy_gap", 32'(bsy), 32'd1);
      chk("done_pulse", 32'(fd), (g == 0) ? 32'd1 : 32'd0);
      chk_mirror();
      step();
    end
    chk("ready_after_gap", 32'(rdy), 32'd1);
    chk("busy_after_gap", 32'(bsy), 32'd0);
    chk("done_after_gap", 32'(fd), 32'd0);
  endtask

  initial begin
    logic [TW-1:0] w1, w2, wr;
    RST = 1'b1; dv = 1'b0; dv0 = 1'b0; di = '0; di0 = '0;
    ex = 1'b0; ex0 = 1'b0; m = 2'b00; m0 = 2'b00;
    do_reset();

    // Reset state
    chk("rst_ready", 32'(rdy), 32'd1);
    chk("rst_x", 32'(xo), 32'd0);
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_done", 32'(fd), 32'd0);
    chk("rst_mirror", 32'(ms), 32'd0);
    chk("rst_y", 32'(my), 32'd0);
    chk("rst_ready0", 32'(rdy0), 32'd1);
    $display("reset checked");

    frame(8'hA5);
    $display("frame A5 sent");

    do_reset();
    frame(8'h0F);
    $display("frame 0F sent, mirror traced");

    // GAP=0 MSB-first instance, data_valid held high over two words
    w1 = 8'hC3; w2 = 8'h5A;
    chk("ready0_first", 32'(rdy0), 32'd1);
    dv0 = 1'b1; di0 = w1;
    for (int i = TW - 1; i >= 0; i--) q0.push_back(w1[i]);
    if (PLEN == 1) q0.push_back(^w1);
    step();
    di0 = w2;
    while (q0.size() > 0) begin
      ex0 = q0.pop_front();
      chk("x0_bit_w1", 32'(xo0), 32'(ex0));
      chk("ready0_busy", 32'(rdy0), 32'd0);
      chk("done0_early", 32'(fd0), 32'd0);
      chk_mirror();
      step();
    end
    ex0 = 1'b0;
    chk("done0_w1", 32'(fd0), 32'd1);
    chk("ready0_second_hs", 32'(rdy0), 32'd1);
    chk("x0_end_w1", 32'(xo0), 32'd0);
    for (int i = TW - 1; i >= 0; i--) q0.push_back(w2[i]);
    if (PLEN == 1) q0.push_back(^w2);
    step();
    dv0 = 1'b0;
    while (q0.size() > 0) begin
      ex0 = q0.pop_front();
      chk("x0_bit_w2", 32'(xo0), 32'(ex0));
      chk("done0_early2", 32'(fd0), 32'd0);
      chk_mirror();
      step();
    end
    ex0 = 1'b0;
    chk("done0_w2", 32'(fd0), 32'd1);
    chk("ready0_end", 32'(rdy0), 32'd1);
    step();
    chk("done0_cleared", 32'(fd0), 32'd0);
    chk_mirror();
    $display("gap0 back-to-back words sent");

    // Reset mid-frame: RST sampled at the edge closing cycle T+4
    w1 = 8'h3C;
    chk("ready_abort_hs", 32'(rdy), 32'd1);
    dv = 1'b1; di = w1; ex = 1'b0;
    step();
    dv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ex = w1[k];
      chk("x_abort_bit", 32'(xo), 32'(ex));
      chk_mirror();
      if (k == 3) RST = 1'b1;
      step();
    end
    RST = 1'b0;
    m = 2'b00; m0 = 2'b00; ex = 1'b0; ex0 = 1'b0;
    chk("abort_x", 32'(xo), 32'd0);
    chk("abort_ready", 32'(rdy), 32'd1);
    chk("abort_busy", 32'(bsy), 32'd0);
    chk("abort_mirror", 32'(ms), 32'd0);
    for (int c = 0; c < TW + 3; c++) begin
      chk("abort_no_done", 32'(fd), 32'd0);
      chk("abort_x_idle", 32'(xo), 32'd0);
      step();
    end
    $display("mid-frame reset checked");

    // Back-to-back random words at the minimum frame period
    for (int n = 0; n < 3; n++) begin
      wr = TW'($urandom);
      frame(wr);
      $display("random frame %0h sent", wr);
    end
    frame(8'hFF);
    $display("frame FF sent");
    frame(8'h00);
    $display("frame 00 sent");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
